fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage of the copperv core. It is the master on the i_raddr channel
//   (ir_addr_*) and the slave on the i_rdata channel (ir_data_*).
// - Buffers returned instructions in a small FIFO and hands them to decode over a valid/ready
//   pair, each tagged with its PC.
// - Supports redirects (branch/jump) with flush and discard of in-flight responses.
// PARAMETERS
// - inst_width  32   instruction/data width
// - pc_width    32   PC/address width
// - pc_init     0    first fetch address after reset
// - fifo_depth  2    instruction FIFO entries (power of 2, >=2); also the max outstanding requests
// PORTS
// - clock           in   1           rising-edge clock
// - reset           in   1           synchronous, active-high reset
// - ir_addr_valid   out  1           fetch request valid
// - ir_addr_ready   in   1           memory accepts request
// - ir_addr         out  pc_width    fetch address
// - ir_data_valid   in   1           instruction response valid
// - ir_data_ready   out  1           fetch accepts response
// - ir_data         in   inst_width  instruction response
// - inst_valid      out  1           instruction available to decode
// - inst_ready      in   1           decode consumes instruction
// - inst            out  inst_width  FIFO head instruction
// - inst_pc         out  pc_width    PC of FIFO head
// - redirect        in   1           one-cycle redirect strobe
// - redirect_pc     in   pc_width    redirect target
// - fetch_count     out  32          retired-to-decode counter (only with FETCH_STATS_EN)
// BEHAVIOUR
// - Reset values: ir_addr_valid=0, ir_addr=pc_init, ir_data_ready=0, inst_valid=0, inst=0,
//   inst_pc=0; FIFO empty; outstanding=0; discard=0; fetch_count=0.
// - Reset mid-operation: all state returns to reset values on the next edge.
//   - Responses still in flight are lost; the memory side is reset with the core.
// - First ir_addr handshake after reset carries ir_addr==pc_init.
//   - ir_addr_valid rises no earlier than the first cycle with reset low.
// - Request issue: ir_addr_valid=1 when (outstanding + fifo_count) < fifo_depth.
//   - Once asserted, ir_addr_valid and ir_addr stay stable until ir_addr_ready.
//   - On handshake: outstanding++, and the fetch PC advances by 4 (wraps mod 2^pc_width).
// - Response: ir_data_ready=1 iff outstanding>0.
//   - On handshake: outstanding--.
//   - If discard>0: discard--, data dropped.
//   - Else: {ir_data, pc} pushed into the FIFO. The PC comes from an in-flight PC queue of
//     depth fifo_depth.
// - Requests and responses are in order; simultaneous request and response handshakes
//   leave outstanding unchanged.
// - Decode side: inst_valid = FIFO non-empty; inst/inst_pc show the head (registered FIFO,
//   so fetch-to-decode latency >= 1 cycle). Pop on inst_valid && inst_ready.
// - FIFO full: no new requests are issued, since entries are reserved by the outstanding count.
//   FIFO push while full is impossible by construction and is an assertion error.
// - Redirect (highest priority):
//   - FIFO flushed; the same-cycle pop is ignored.
//   - discard = outstanding after this cycle's handshakes. A same-cycle response is dropped;
//     a same-cycle ir_addr handshake counts toward discard.
//   - Fetch PC <= redirect_pc.
//   - A pending unaccepted request stays stable until accepted, then counts toward discard.
//     redirect_pc is issued next.
// - State machine:
//   - FETCH: normal operation.
//   - DRAIN: discard>0. Issue continues; dropped responses never reach the FIFO.
//   - DRAIN->FETCH when discard reaches 0.
//   - Redirect in DRAIN adds to discard.
// - redirect_pc[1:0]!=0 is not checked; the address is used as given.
// CONFIGURATION
// - FETCH_STATS_EN defined: the fetch_count port exists.
//   - 32-bit counter, +1 per decode handshake.
//   - Wraps 0xFFFFFFFF->0; cleared by reset.
// - FETCH_STATS_EN undefined: no port and no counter; behaviour is otherwise identical.
// TESTING
// - Release reset with memory always ready -> first ir_addr=0x0, then 0x4, 0x8; decode sees
//   inst_pc 0x0,0x4,0x8 in order.
// - Hold inst_ready=0 with fifo_depth=2 -> exactly 2 requests issue; ir_addr_valid stays 0
//   until a pop.
// - Hold ir_addr_ready=0 for 5 cycles -> ir_addr_valid=1 and ir_addr stable for all 5 cycles.
// - Redirect to 0x100 with 2 outstanding -> both responses dropped; the next inst_pc is 0x100.
// - Redirect in the same cycle as a response and a pop -> FIFO empty next cycle; the
//   response is not delivered.
// - Assert reset with 2 outstanding and FIFO full -> next cycle all outputs at reset values;
//   the first request after release is 0x0.
// - With FETCH_STATS_EN: 7 decode handshakes -> fetch_count==7; reset -> 0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: instruction fetch stage; issues in-order memory requests,       |
// | buffers responses with their PCs, handles redirects with discard of stale   |
// | responses. Optional macro FETCH_STATS_EN adds the fetch_count port.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_unit #(
  parameter int                  INST_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] PC_INIT    = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ir_addr_valid,
  input  logic                  ir_addr_ready,
  output logic [PC_WIDTH-1:0]   ir_addr,
  input  logic                  ir_data_valid,
  output logic                  ir_data_ready,
  input  logic [INST_WIDTH-1:0] ir_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  redirect,
`ifdef FETCH_STATS_EN
  output logic [31:0]           fetch_count,
`endif
  input  logic [PC_WIDTH-1:0]   redirect_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FIFO_LIM  = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   ISSUE_LIM = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic                  stale_q, stale_d;
  logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [PC_WIDTH-1:0]   pcq_mem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   pcq_mem_d [FIFO_DEPTH];
  logic [AW-1:0]         pcq_wr_q, pcq_wr_d;
  logic [AW-1:0]         pcq_rd_q, pcq_rd_d;

  logic [INST_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_d [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]   fifo_pc_d [FIFO_DEPTH];
  logic [AW-1:0]         fifo_wr_q, fifo_wr_d;
  logic [AW-1:0]         fifo_rd_q, fifo_rd_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;

`ifdef FETCH_STATS_EN
  logic [31:0]           fetch_count_q, fetch_count_d;
`endif

  logic [CW:0]           inflight;
  logic                  req_hs;
  logic                  resp_hs;
  logic                  pop;
  logic                  drop;
  logic                  push;
  logic [PC_WIDTH-1:0]   resp_pc;

  // Every issued request reserves a FIFO slot, so a push can never find the FIFO full.
  assign inflight      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign ir_addr_valid = !reset && (inflight < ISSUE_LIM);
  assign ir_addr       = fetch_pc_q;
  assign ir_data_ready = (outstanding_q != '0);
  assign inst_valid    = (fifo_cnt_q != '0);
  assign inst          = fifo_inst_q[fifo_rd_q];
  assign inst_pc       = fifo_pc_q[fifo_rd_q];

  assign req_hs  = ir_addr_valid && ir_addr_ready;
  assign resp_hs = ir_data_valid && ir_data_ready;
  assign pop     = inst_valid && inst_ready && !redirect;
  assign drop    = (state_q == ST_DRAIN) || redirect;
  assign push    = resp_hs && !drop;
  assign resp_pc = pcq_mem_q[pcq_rd_q];

`ifdef FETCH_STATS_EN
  assign fetch_count = fetch_count_q;
`endif

  // Request side, outstanding/discard accounting and drain state
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    stale_d       = stale_q;
    redir_pc_d    = redir_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    state_d       = state_q;

    if (req_hs && !resp_hs) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!req_hs && resp_hs) begin
      outstanding_d = outstanding_q - CW'(1);
    end

    if (redirect) begin
      // A request already on the bus must hold its address; it becomes stale instead.
      if (ir_addr_valid && !ir_addr_ready) begin
        stale_d    = 1'b1;
        redir_pc_d = redirect_pc;
      end else begin
        stale_d    = 1'b0;
        fetch_pc_d = redirect_pc;
      end
      discard_d = outstanding_d;
    end else begin
      if (req_hs) begin
        fetch_pc_d = stale_q ? redir_pc_q : (fetch_pc_q + PC_WIDTH'(4));
        stale_d    = 1'b0;
        if (stale_q) begin
          discard_d = discard_d + CW'(1);
        end
      end
      if (resp_hs && (state_q == ST_DRAIN)) begin
        discard_d = discard_d - CW'(1);
      end
    end

    state_d = (discard_d != '0) ? ST_DRAIN : ST_FETCH;
  end

  // In-flight PC queue: one entry per accepted request, consumed in order by responses
  always_comb begin
    pcq_mem_d = pcq_mem_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    if (req_hs) begin
      pcq_mem_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d            = pcq_wr_q + AW'(1);
    end
    if (resp_hs) begin
      pcq_rd_d = pcq_rd_q + AW'(1);
    end
  end

  // Instruction FIFO towards decode
  always_comb begin
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_cnt_d  = fifo_cnt_q;
    if (redirect) begin
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
    end else begin
      if (push) begin
        fifo_inst_d[fifo_wr_q] = ir_data;
        fifo_pc_d[fifo_wr_q]   = resp_pc;
        fifo_wr_d              = fifo_wr_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end
      if (push && !pop) begin
        fifo_cnt_d = fifo_cnt_q + CW'(1);
      end else if (!push && pop) begin
        fifo_cnt_d = fifo_cnt_q - CW'(1);
      end
    end
  end

`ifdef FETCH_STATS_EN
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (pop) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      fetch_pc_q    <= PC_INIT;
      stale_q       <= 1'b0;
      redir_pc_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      pcq_mem_q     <= '{default: '0};
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      fifo_inst_q   <= '{default: '0};
      fifo_pc_q     <= '{default: '0};
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
`ifdef FETCH_STATS_EN
      fetch_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      stale_q       <= stale_d;
      redir_pc_q    <= redir_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pcq_mem_q     <= pcq_mem_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
      fifo_inst_q   <= fifo_inst_d;
      fifo_pc_q     <= fifo_pc_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
`ifdef FETCH_STATS_EN
      fetch_count_q <= fetch_count_d;
`endif
    end
  end

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && (fifo_cnt_q == FIFO_LIM)));

endmodule
`default_nettype wire
